// File: rtl/key_sched_8.sv
// Byte-serial AES-128 key schedule: loads a 16-byte cipher key, then streams
// all 11 round keys one byte per advance, with a fixed-delay copy for the datapath.
module key_sched_8 #(
    parameter int unsigned RK_DLY = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] key_in,
    input  logic       key_ld,
    input  logic       start,
    input  logic       key_adv,
    output logic [7:0] rk_out,
    output logic [7:0] rk_dly,
    output logic       rk_valid,
    output logic [3:0] round,
    output logic       last_round,
    output logic       key_ready
);

    typedef enum logic [1:0] {EMPTY, LOAD, READY, ROUND} state_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_rk [16];
    logic [7:0] r_bk [16];
    logic [7:0] r_rcon;
    logic [3:0] r_byte_cnt;
    logic [3:0] r_round_cnt;
    logic [7:0] r_dly [RK_DLY];

    logic       w_shift;
    logic       w_load_bk;
    logic [7:0] w_shift_in;
    logic [3:0] w_cnt_nxt;
    logic [3:0] w_round_nxt;
    logic [7:0] w_rcon_nxt;
    logic [7:0] w_sbox_in;
    logic [7:0] w_sbox_out;
    logic [7:0] w_xtime;
    logic [7:0] w_gen;

    // One S-box lookup per cycle: tap 9 holds RotWord's last byte at j=3.
    assign w_sbox_in  = (r_byte_cnt == 4'd3) ? r_rk[9] : r_rk[13];
    assign w_sbox_out = SBOX[w_sbox_in];
    assign w_xtime    = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

    always_comb begin
        w_gen = r_rk[0] ^ r_rk[12];
        if (r_round_cnt == 4'd10) begin
            w_gen = r_bk[r_byte_cnt];
        end else if (r_byte_cnt == 4'd0) begin
            w_gen = r_rk[0] ^ w_sbox_out ^ r_rcon;
        end else if (r_byte_cnt <= 4'd3) begin
            w_gen = r_rk[0] ^ w_sbox_out;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift     = 1'b0;
        w_load_bk   = 1'b0;
        w_shift_in  = key_in;
        w_cnt_nxt   = r_byte_cnt;
        w_round_nxt = r_round_cnt;
        w_rcon_nxt  = r_rcon;
        case (r_state)
            EMPTY: begin
                if (key_ld) begin
                    w_shift     = 1'b1;
                    w_cnt_nxt   = 4'd1;
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (key_ld) begin
                    w_shift   = 1'b1;
                    w_cnt_nxt = r_byte_cnt + 4'd1;
                    if (r_byte_cnt == 4'd15) begin
                        w_load_bk   = 1'b1;
                        w_state_nxt = READY;
                    end
                end
            end
            READY: begin
                if (key_ld) begin
                    w_shift     = 1'b1;
                    w_cnt_nxt   = 4'd1;
                    w_state_nxt = LOAD;
                end else if (start) begin
                    w_cnt_nxt   = '0;
                    w_round_nxt = '0;
                    w_rcon_nxt  = 8'h01;
                    w_state_nxt = ROUND;
                end
            end
            ROUND: begin
                if (key_adv) begin
                    w_shift    = 1'b1;
                    w_shift_in = w_gen;
                    w_cnt_nxt  = r_byte_cnt + 4'd1;
                    if (r_byte_cnt == 4'd15) begin
                        w_rcon_nxt  = w_xtime;
                        w_round_nxt = r_round_cnt + 4'd1;
                        if (r_round_cnt == 4'd10) begin
                            w_rcon_nxt  = 8'h01;
                            w_round_nxt = '0;
                            w_state_nxt = READY;
                        end
                    end
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= EMPTY;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 16; i++) begin
                r_rk[i] <= '0;
                r_bk[i] <= '0;
            end
            r_rcon      <= 8'h01;
            r_byte_cnt  <= '0;
            r_round_cnt <= '0;
        end else begin
            if (w_shift) begin
                for (int unsigned i = 0; i < 15; i++) r_rk[i] <= r_rk[i+1];
                r_rk[15] <= w_shift_in;
            end
            // Backup captures the post-shift key, i.e. including the 16th byte.
            if (w_load_bk) begin
                for (int unsigned i = 0; i < 15; i++) r_bk[i] <= r_rk[i+1];
                r_bk[15] <= key_in;
            end
            r_rcon      <= w_rcon_nxt;
            r_byte_cnt  <= w_cnt_nxt;
            r_round_cnt <= w_round_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < RK_DLY; i++) r_dly[i] <= '0;
        end else begin
            r_dly[0] <= r_rk[0];
            for (int unsigned i = 1; i < RK_DLY; i++) r_dly[i] <= r_dly[i-1];
        end
    end

    assign rk_out     = r_rk[0];
    assign rk_dly     = r_dly[RK_DLY-1];
    assign rk_valid   = (r_state == ROUND);
    assign round      = r_round_cnt;
    assign last_round = (r_state == ROUND) && (r_round_cnt == 4'd10);
    assign key_ready  = (r_state == READY);

endmodule

// File: tb/tb_key_sched_8.sv
// Bench for key_sched_8: per-cycle transaction model with a key expansion built
// from a GF(2^8)-derived S-box, plus FIPS-197 round-key vectors.
module tb_key_sched_8;

    localparam int DLY = 4;
    localparam int M_EMPTY = 0, M_LOAD = 1, M_READY = 2, M_ROUND = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] key_in = 8'h00;
    logic       key_ld = 1'b0;
    logic       start = 1'b0;
    logic       key_adv = 1'b0;
    logic [7:0] rk_out;
    logic [7:0] rk_dly;
    logic       rk_valid;
    logic [3:0] round;
    logic       last_round;
    logic       key_ready;

    always #5 clk = ~clk;

    key_sched_8 #(.RK_DLY(DLY)) dut (
        .clk(clk), .rst(rst), .key_in(key_in), .key_ld(key_ld), .start(start),
        .key_adv(key_adv), .rk_out(rk_out), .rk_dly(rk_dly), .rk_valid(rk_valid),
        .round(round), .last_round(last_round), .key_ready(key_ready)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int m_mode = M_EMPTY;
    int m_cnt = 0;
    int m_idx = 0;
    logic [7:0] sb [256];
    logic [7:0] m_sr [16];
    logic [7:0] m_exp [176];
    logic [7:0] cap [176];
    logic [7:0] kbuf [16];
    logic [7:0] hist [8192];

    typedef struct {
        logic [127:0] key;
        int           rnd;
        logic [127:0] rk;
    } vec_t;
    vec_t tbl [5];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(logic [7:0] x, int n);
        logic [15:0] y = {x, x} << n;
        return y[15:8];
    endfunction

    task automatic build_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic model_expand();
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++)
            w[i] = {m_sr[4*i], m_sr[4*i+1], m_sr[4*i+2], m_sr[4*i+3]};
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 176; i++)
            m_exp[i] = 8'(w[i/4] >> (24 - 8*(i%4)));
    endtask

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: drive inputs, advance the model on the edge, check outputs #1 later.
    task automatic tick(logic r, logic ld, logic [7:0] kin, logic st, logic adv);
        logic [7:0] e;
        rst = r; key_ld = ld; key_in = kin; start = st; key_adv = adv;
        if (!r && m_mode == M_ROUND && adv) cap[m_idx] = rk_out;
        @(posedge clk);
        if (r) begin
            m_mode = M_EMPTY; m_cnt = 0; m_idx = 0;
            for (int i = 0; i < 16; i++) m_sr[i] = 8'h00;
        end else if (m_mode == M_ROUND) begin
            if (adv) begin
                m_idx++;
                if (m_idx == 176) begin m_mode = M_READY; m_idx = 0; end
            end
        end else if (ld) begin
            for (int i = 0; i < 15; i++) m_sr[i] = m_sr[i+1];
            m_sr[15] = kin;
            if (m_mode == M_LOAD && m_cnt == 15) begin
                m_cnt = 0; m_mode = M_READY; model_expand();
            end else begin
                m_cnt = (m_mode == M_LOAD) ? m_cnt + 1 : 1;
                m_mode = M_LOAD;
            end
        end else if (m_mode == M_READY && st) begin
            m_mode = M_ROUND; m_idx = 0;
        end
        cyc++;
        e = (m_mode == M_ROUND) ? m_exp[m_idx] : m_sr[0];
        hist[cyc] = e;
        if (r) for (int k = 0; k <= DLY; k++) if (cyc - k >= 0) hist[cyc-k] = 8'h00;
        #1;
        chk("rk_out", 128'(rk_out), 128'(e));
        chk("rk_dly", 128'(rk_dly), 128'((cyc >= DLY) ? hist[cyc-DLY] : 8'h00));
        chk("rk_valid", 128'(rk_valid), 128'(m_mode == M_ROUND));
        chk("key_ready", 128'(key_ready), 128'(m_mode == M_READY));
        chk("last_round", 128'(last_round), 128'(m_mode == M_ROUND && m_idx >= 160));
        if (m_mode == M_ROUND) chk("round", 128'(round), 128'(m_idx / 16));
    endtask

    task automatic load_key(int gap_pct, logic st_first);
        for (int i = 0; i < 16; i++) begin
            if (i > 0)
                while ($urandom_range(99) < gap_pct)
                    tick(1'b0, 1'b0, 8'($urandom), 1'($urandom), 1'($urandom));
            tick(1'b0, 1'b1, kbuf[i], (i == 0) ? st_first : 1'b0, 1'($urandom));
        end
    endtask

    task automatic run_stream(int adv_pct, logic junk, int stop_at);
        int n = 0;
        tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        while (m_mode == M_ROUND && m_idx != stop_at && n < 4000) begin
            tick(1'b0, junk & 1'($urandom), 8'($urandom), junk & 1'($urandom),
                 1'($urandom_range(99) < adv_pct));
            n++;
        end
        chk("stream_budget", 128'(n < 4000), 128'd1);
    endtask

    task automatic chk_round(string name, int rnd, logic [127:0] exp);
        logic [127:0] got = '0;
        for (int b = 0; b < 16; b++) got = {got[119:0], cap[16*rnd+b]};
        chk(name, got, exp);
    endtask

    task automatic set_key(logic [127:0] k);
        for (int i = 0; i < 16; i++) kbuf[i] = 8'(k >> (120 - 8*i));
    endtask

    initial begin
        tbl[0] = '{FIPS_KEY, 0, FIPS_KEY};
        tbl[1] = '{FIPS_KEY, 1, FIPS_R1};
        tbl[2] = '{FIPS_KEY, 2, 128'hf2c295f27a96b9435935807a7359f67f};
        tbl[3] = '{FIPS_KEY, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        tbl[4] = '{128'h0, 1, 128'h62636363626363636263636362636363};
        for (int i = 0; i < 16; i++) m_sr[i] = 8'h00;
        for (int i = 0; i < 8192; i++) hist[i] = 8'h00;
        build_sbox();

        // Reset, then start alone must be ignored
        tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        chk("reset_round", 128'(round), 128'd0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        // Known-answer vectors
        for (int v = 0; v < 5; v++) begin
            set_key(tbl[v].key);
            load_key(0, 1'b0);
            run_stream(100, 1'b0, -1);
            chk_round("tbl_round_key", tbl[v].rnd, tbl[v].rk);
        end

        // Back-to-back streams, second one starting in the first READY cycle
        set_key(FIPS_KEY);
        load_key(0, 1'b0);
        run_stream(100, 1'b0, -1);
        run_stream(100, 1'b0, -1);
        chk_round("b2b_r0", 0, FIPS_KEY);
        chk_round("b2b_r1", 1, FIPS_R1);

        // Random stalls on the same key
        run_stream(50, 1'b0, -1);
        chk_round("stall_r1", 1, FIPS_R1);

        // Random key with load gaps, stalls and ignored ld/start during ROUND
        for (int i = 0; i < 16; i++) kbuf[i] = 8'($urandom);
        load_key(30, 1'b0);
        run_stream(50, 1'b1, -1);

        // Reload in READY overrides the old key, key_ld beating start
        for (int i = 0; i < 16; i++) kbuf[i] = 8'($urandom);
        load_key(0, 1'b0);
        set_key(FIPS_KEY);
        load_key(0, 1'b1);
        run_stream(70, 1'b1, -1);
        chk_round("override_r1", 1, FIPS_R1);

        // Reset at round 5 byte 7, then reload and restream
        run_stream(60, 1'b0, 5*16 + 7);
        tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("midreset_round", 128'(round), 128'd0);
        tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        load_key(20, 1'b0);
        run_stream(100, 1'b0, -1);
        chk_round("reload_r0", 0, FIPS_KEY);
        chk_round("reload_r10", 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        for (int i = 0; i < DLY + 2; i++) tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/key_sched_8.md
# key_sched_8

Byte-serial AES-128 key-schedule stage that sits directly upstream of the 8-bit round datapath. It accepts the 16-byte cipher key one byte per clock and stores it. It then streams all 11 round keys (176 bytes) one byte per advance in the same byte order as the data stream. It also provides a fixed-delay copy of the key stream for the datapath's pre-permutation XOR. Each next round key is computed on the fly while the current one is shifted out, and the cipher key is restored automatically after round 10.

## Interface
- RK_DLY, 4, clock delay of rk_dly relative to rk_out; legal range 1..16.

- clk  in  1  sole clock, rising edge
- rst  in  1  reset, synchronous, active-high
- key_in  in  8  cipher key byte; k0 first, column-major (FIPS-197 byte order)
- key_ld  in  1  key_in is captured this cycle
- start  in  1  begin key streaming (one-cycle pulse)
- key_adv  in  1  datapath consumes rk_out this cycle
- rk_out  out  8  current round-key byte
- rk_dly  out  8  rk_out delayed RK_DLY clocks
- rk_valid  out  1  streaming active (state ROUND)
- round  out  4  index of the round key being output, 0..10
- last_round  out  1  rk_valid and round == 10
- key_ready  out  1  complete key stored, idle

## Operation
- Storage:
  - rk[0..15] is a 16-byte working shift register; rk_out = rk[0].
  - bk[0..15] is the backup copy of the cipher key.
  - rcon is 8 bits; byte_cnt and round_cnt are 4 bits each.
- States: EMPTY, LOAD, READY, ROUND.
- EMPTY:
  - key_ld=1: rk shifts toward index 0 and key_in enters at rk[15]; byte_cnt=1; go to LOAD.
  - start is ignored.
- LOAD:
  - Each cycle with key_ld=1: shift in one byte and increment byte_cnt.
  - key_ld=0 pauses the load with no state change.
  - The 16th byte (byte_cnt 15→0 wrap) moves to READY and copies the updated rk into bk in the same edge.
  - start is ignored.
- READY:
  - start=1 moves to ROUND with round_cnt=0, byte_cnt=0 and rcon=0x01.
  - key_ld=1 (even if start is also asserted) restarts LOAD with this byte as k0, discarding the old key. key_ld wins over start.
- ROUND, each cycle with key_adv=1 (j = byte_cnt): rk shifts and new byte n enters at rk[15].
  - j=0..2: n = rk[0] ^ S(rk[13]), plus ^rcon when j=0.
  - j=3: n = rk[0] ^ S(rk[9]).
  - j=4..15: n = rk[0] ^ rk[12].
  - When round_cnt=10: n = bk[j] instead, which restores the cipher key.
  - S is the codebase's shared combinational S-box, used once per cycle (mux on tap 13 or 9).
- ROUND, end of round (j=15 consumed):
  - rcon <= xtime(rcon), where xtime = {rcon[6:0],1'b0} ^ (rcon[7] ? 0x1b : 0).
  - round_cnt increments.
  - After round 10 ends, go to READY with rcon=0x01.
- ROUND, inputs:
  - key_adv=0 stalls: no register changes.
  - key_ld and start are ignored.
- rk_dly is an RK_DLY-deep byte pipeline fed from rk_out. It advances every clock regardless of key_adv.

## Timing
- Reset: state EMPTY; rk, bk and the delay pipe all 0x00; rcon=0x01; counters 0.
  - Outputs: rk_out=0x00, rk_dly=0x00, rk_valid=0, round=0, last_round=0, key_ready=0.
- Load latency: key_ready rises the clock after the 16th key_ld cycle.
- start at edge t: rk_valid=1 and rk_out=k0 from edge t onward, so the first byte is consumable in cycle t+1.
- A byte is consumed on the edge where key_adv=1. The next byte appears on rk_out with no bubble, so 176 back-to-back advances stream all keys.
- key_ready=1 again in the cycle after the 176th advance. start is accepted in that same cycle.
- rst mid-LOAD or mid-ROUND returns to EMPTY next edge with all outputs at reset values. The key is lost and must be reloaded.
- round, last_round and rk_valid are registered/state-decoded and change only on edges.

## Test plan
- Reset state: rst held 2 cycles → all outputs 0; start alone does nothing, key_ready stays 0.
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c loaded in 16 cycles, start, key_adv=1 continuously:
  - Bytes 0-15 equal the cipher key.
  - Bytes 16-31 = a0fafe1788542cb123a339392a6c7605.
  - Bytes 160-175 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - last_round=1 exactly for the final 16 bytes.
- Stalls: same key, key_adv random 50% → identical byte sequence on advance cycles; rk_out stable across stall cycles.
- Back-to-back: after the first 176 bytes, start immediately → second stream repeats 2b7e...4f3c, a0fa...7605 unchanged.
- Load pause and override:
  - key_ld gaps mid-load → key still assembled correctly.
  - key_ld in READY → new key replaces the old.
  - key_ld and start both in ROUND → ignored.
- rst asserted at round 5, byte 7 → EMPTY next edge, outputs 0; reload, and the stream restarts from round 0 correctly.
- rk_dly: with RK_DLY=4, rk_dly equals rk_out from 4 clocks earlier throughout, including across stalls.
